poly_fir_decim_prog: RTL and testbench

- Runtime-programmable, parametrised decimating FIR.
- Successor to the fixed-coefficient polyphase stage-1 decimator. Adds loadable coefficients, runtime output shift, ready/valid handshakes on both sides, a phase-resync input and sticky status flags.
- Uses one time-shared multiplier, so it fits low-rate chain stages where area matters more than throughput.
- Produces one output per DECIMATION_FACTOR accepted input samples.

---
 rtl/poly_fir_decim_prog.sv | 209 ++++++++++++++++++++
 tb/tb_poly_fir_decim_prog.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_fir_decim_prog.sv
// rtl/poly_fir_decim_prog.sv - programmable decimating FIR with one time-shared multiplier
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   sync                 synchronous resync (history, phase, in-flight result)
//   din/din_valid/din_ready      input sample stream
//   dout/dout_valid/dout_ready   decimated, scaled, saturated output stream
//   cfg_shift            arithmetic right shift applied to the accumulator at output load
//   coef_wr_en/addr/data coefficient write port, accepted only while idle
//   sat_flag, coef_wr_err        sticky status flags, cleared by stat_clr
module poly_fir_decim_prog #(
    parameter int DECIMATION_FACTOR = 9,
    parameter int TAP_LEN           = 63,
    parameter int DATA_WIDTH        = 16,
    parameter int COEF_WIDTH        = 16,
    parameter int SHIFT_WIDTH       = 6,
    localparam int ACC_W            = DATA_WIDTH + COEF_WIDTH + $clog2(TAP_LEN),
    localparam int AW               = $clog2(TAP_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sync,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic                         coef_wr_en,
    input  logic [AW-1:0]                coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
    output logic                         sat_flag,
    output logic                         coef_wr_err,
    input  logic                         stat_clr
);

    localparam int PW  = DATA_WIDTH + COEF_WIDTH;
    localparam int PHW = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
    localparam int MCW = $clog2(TAP_LEN + 2);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state;

    logic signed [DATA_WIDTH-1:0] hist [TAP_LEN];
    logic signed [COEF_WIDTH-1:0] coef [TAP_LEN];

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [PHW-1:0] phase;
    logic [MCW-1:0] mcnt;

    // three-stage MAC pipeline: operand read, multiply, accumulate
    logic                         rd_vld;
    logic                         mul_vld;
    logic signed [DATA_WIDTH-1:0] samp_q;
    logic signed [COEF_WIDTH-1:0] coef_q;
    logic signed [PW-1:0]         prod_q;
    logic signed [ACC_W-1:0]      acc;

    logic                         accept;
    logic                         trigger;
    logic                         coef_ok;
    logic                         coef_bad;
    logic                         load;
    logic                         issue;
    logic                         sat_hi;
    logic                         sat_lo;
    logic signed [ACC_W-1:0]      scaled;
    logic signed [DATA_WIDTH-1:0] sat_val;

    assign accept   = din_valid && din_ready && !sync;
    assign trigger  = accept && (phase == PHW'(DECIMATION_FACTOR - 1));
    assign coef_ok  = coef_wr_en && (state == IDLE) &&
                      ({1'b0, coef_wr_addr} < (AW+1)'(TAP_LEN));
    assign coef_bad = coef_wr_en && !coef_ok;
    assign load     = !sync && (state == OUT) && (!dout_valid || dout_ready);
    assign issue    = (state == MAC) && (mcnt < MCW'(TAP_LEN));

    assign scaled  = acc >>> cfg_shift;
    assign sat_hi  = scaled > SAT_MAX;
    assign sat_lo  = scaled < SAT_MIN;
    assign sat_val = sat_hi ? SAT_MAX[DATA_WIDTH-1:0] :
                     sat_lo ? SAT_MIN[DATA_WIDTH-1:0] : scaled[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            din_ready   <= 1'b1;
            dout        <= '0;
            dout_valid  <= 1'b0;
            sat_flag    <= 1'b0;
            coef_wr_err <= 1'b0;
            phase       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mcnt        <= '0;
            rd_vld      <= 1'b0;
            mul_vld     <= 1'b0;
            samp_q      <= '0;
            coef_q      <= '0;
            prod_q      <= '0;
            acc         <= '0;
            for (int i = 0; i < TAP_LEN; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            // coefficients live outside the resync domain
            if (coef_ok) begin
                coef[coef_wr_addr] <= coef_wr_data;
            end

            // sticky flags: a set in the same cycle beats stat_clr
            if (coef_bad) begin
                coef_wr_err <= 1'b1;
            end else if (stat_clr) begin
                coef_wr_err <= 1'b0;
            end
            if (load && (sat_hi || sat_lo)) begin
                sat_flag <= 1'b1;
            end else if (stat_clr) begin
                sat_flag <= 1'b0;
            end

            if (sync) begin
                state      <= IDLE;
                din_ready  <= 1'b1;
                dout_valid <= 1'b0;
                phase      <= '0;
                wr_ptr     <= '0;
                mcnt       <= '0;
                rd_vld     <= 1'b0;
                mul_vld    <= 1'b0;
                for (int i = 0; i < TAP_LEN; i++) begin
                    hist[i] <= '0;
                end
            end else begin
                if (accept) begin
                    hist[wr_ptr] <= din;
                    wr_ptr       <= (wr_ptr == AW'(TAP_LEN - 1)) ? '0 : wr_ptr + AW'(1);
                    phase        <= trigger ? '0 : phase + PHW'(1);
                end

                // tap k reads x[n-k], walking the circular buffer backwards
                rd_vld  <= issue;
                mul_vld <= rd_vld;
                if (issue) begin
                    samp_q <= hist[rd_ptr];
                    coef_q <= coef[mcnt[AW-1:0]];
                    rd_ptr <= (rd_ptr == '0) ? AW'(TAP_LEN - 1) : rd_ptr - AW'(1);
                end
                if (rd_vld) begin
                    prod_q <= PW'(samp_q) * PW'(coef_q);
                end
                if (trigger) begin
                    acc <= '0;
                end else if (mul_vld) begin
                    acc <= acc + ACC_W'(prod_q);
                end

                if (load) begin
                    dout       <= sat_val;
                    dout_valid <= 1'b1;
                end else if (dout_ready) begin
                    dout_valid <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (trigger) begin
                            state     <= MAC;
                            din_ready <= 1'b0;
                            mcnt      <= '0;
                            // the triggering sample lands in the slot wr_ptr points at
                            rd_ptr    <= wr_ptr;
                        end
                    end
                    MAC: begin
                        mcnt <= mcnt + MCW'(1);
                        // TAP_LEN issue cycles plus multiply and accumulate flush
                        if (mcnt == MCW'(TAP_LEN + 1)) begin
                            state <= OUT;
                        end
                    end
                    OUT: begin
                        if (load) begin
                            state     <= IDLE;
                            din_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        din_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_poly_fir_decim_prog.sv
// tb/tb_poly_fir_decim_prog.sv - self-checking bench for poly_fir_decim_prog
module tb_poly_fir_decim_prog;

    localparam int D  = 9;
    localparam int T  = 63;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int SW = 6;
    localparam int AW = 6;
    localparam longint VMAX = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint VMIN = -(64'sd1 <<< (DW - 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sync = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic                 din_valid = 1'b0;
    logic                 din_ready;
    logic signed [DW-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready = 1'b1;
    logic [SW-1:0]        cfg_shift = '0;
    logic                 coef_wr_en = 1'b0;
    logic [AW-1:0]        coef_wr_addr = '0;
    logic signed [CW-1:0] coef_wr_data = '0;
    logic                 sat_flag;
    logic                 coef_wr_err;
    logic                 stat_clr = 1'b0;

    poly_fir_decim_prog #(
        .DECIMATION_FACTOR(D),
        .TAP_LEN(T),
        .DATA_WIDTH(DW),
        .COEF_WIDTH(CW),
        .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sync(sync),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .cfg_shift(cfg_shift),
        .coef_wr_en(coef_wr_en),
        .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data),
        .sat_flag(sat_flag),
        .coef_wr_err(coef_wr_err),
        .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behavioural model: plain convolution over the samples accepted since the last resync
    longint h [T];
    int     hist_q[$];
    int     expq[$];
    int     trigq[$];
    int     obs[$];
    int     mphase = 0;
    bit     err_exp = 1'b0;
    bit     exp_wr_ok = 1'b0;
    bit     lat_chk = 1'b0;
    bit     prev_valid = 1'b0;

    function automatic int model_out();
        longint y = 0;
        int     n = hist_q.size();
        for (int k = 0; k < T; k++) begin
            if (n - 1 - k >= 0) y += h[k] * longint'(hist_q[n - 1 - k]);
        end
        y = y >>> cfg_shift;
        if (y > VMAX) y = VMAX;
        else if (y < VMIN) y = VMIN;
        return int'(y);
    endfunction

    function automatic int obs_at(input int i);
        if (i >= 0 && i < obs.size()) return obs[i];
        return -999999;
    endfunction

    always @(negedge clk) begin : compare
        int  e;
        int  t;
        bit  wr_bad;
        if (rst) begin
            hist_q.delete();
            expq.delete();
            trigq.delete();
            mphase     = 0;
            err_exp    = 1'b0;
            prev_valid = 1'b0;
            for (int k = 0; k < T; k++) h[k] = 0;
        end else begin
            chk(coef_wr_err == err_exp, "coef_wr_err", coef_wr_err, err_exp);
            wr_bad = coef_wr_en && !(exp_wr_ok && int'(coef_wr_addr) < T);
            if (coef_wr_en && !wr_bad) h[coef_wr_addr] = coef_wr_data;
            if (wr_bad) err_exp = 1'b1;
            else if (stat_clr) err_exp = 1'b0;

            if (sync) begin
                hist_q.delete();
                expq.delete();
                trigq.delete();
                mphase = 0;
            end else begin
                if (dout_valid && dout_ready) begin
                    if (expq.size() == 0) begin
                        chk(1'b0, "unexpected_output", dout, 0);
                    end else begin
                        e = expq.pop_front();
                        chk(dout == e, "dout", dout, e);
                    end
                    obs.push_back(int'(dout));
                end
                if (lat_chk && dout_valid && !prev_valid && trigq.size() > 0) begin
                    t = trigq.pop_front();
                    chk(cyc - t == T + 3, "latency", cyc - t, T + 3);
                end
                if (din_valid && din_ready) begin
                    hist_q.push_back(int'(din));
                    if (hist_q.size() > T) void'(hist_q.pop_front());
                    if (mphase == D - 1) begin
                        mphase = 0;
                        expq.push_back(model_out());
                        trigq.push_back(cyc + 1);
                    end else begin
                        mphase++;
                    end
                end
            end
            prev_valid = dout_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bit got = 1'b0;
        din       = v[DW-1:0];
        din_valid = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            got = din_ready;
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        if (!got) chk(1'b0, "din_ready_timeout", 0, 1);
    endtask

    task automatic wcoef(input int a, input int d, input bit ok);
        coef_wr_addr = a[AW-1:0];
        coef_wr_data = d[CW-1:0];
        coef_wr_en   = 1'b1;
        exp_wr_ok    = ok;
        tick();
        coef_wr_en   = 1'b0;
        exp_wr_ok    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && expq.size() != 0; i++) @(negedge clk);
        chk(expq.size() == 0, "drain", expq.size(), 0);
        tick();
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog expired");
    end

    int imp[8] = '{9, 18, 27, 36, 45, 54, 63, 0};

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(dout == 0, "rst_dout", dout, 0);
        chk(dout_valid == 0, "rst_dout_valid", dout_valid, 0);
        chk(din_ready == 1, "rst_din_ready", din_ready, 1);
        chk(sat_flag == 0, "rst_sat_flag", sat_flag, 0);
        chk(coef_wr_err == 0, "rst_coef_wr_err", coef_wr_err, 0);
        rst = 1'b0;
        tick();

        // impulse response, with latency checked on every output
        for (int k = 0; k < T; k++) wcoef(k, k + 1, 1'b1);
        cfg_shift = 0;
        obs.delete();
        trigq.delete();
        lat_chk = 1'b1;
        send(1);
        for (int i = 1; i < 8 * D; i++) send(0);
        drain();
        lat_chk = 1'b0;
        chk(obs.size() == 8, "impulse_count", obs.size(), 8);
        for (int i = 0; i < 8; i++) chk(obs_at(i) == imp[i], "impulse_lit", obs_at(i), imp[i]);
        chk(sat_flag == 0, "impulse_sat_flag", sat_flag, 0);

        // DC gain ramp
        pulse_sync();
        for (int k = 0; k < T; k++) wcoef(k, 1024, 1'b1);
        cfg_shift = 10;
        obs.delete();
        for (int i = 0; i < 8 * D; i++) send(100);
        drain();
        chk(obs_at(0) == 900, "dc_first", obs_at(0), 900);
        chk(obs_at(5) == 5400, "dc_sixth", obs_at(5), 5400);
        chk(obs_at(6) == 6300, "dc_seventh", obs_at(6), 6300);
        chk(obs_at(7) == 6300, "dc_eighth", obs_at(7), 6300);

        // saturation both ways, then stat_clr racing a bad write
        pulse_sync();
        for (int k = 0; k < T; k++) wcoef(k, 1291, 1'b1);
        cfg_shift = 15;
        obs.delete();
        for (int i = 0; i < 7 * D; i++) send(32767);
        drain();
        chk(obs_at(obs.size() - 1) == 32767, "sat_max", obs_at(obs.size() - 1), 32767);
        chk(sat_flag == 1, "sat_flag_set", sat_flag, 1);
        obs.delete();
        for (int i = 0; i < 7 * D; i++) send(-32768);
        drain();
        chk(obs_at(obs.size() - 1) == -32768, "sat_min", obs_at(obs.size() - 1), -32768);
        stat_clr = 1'b1;
        wcoef(63, 5, 1'b1);
        stat_clr = 1'b0;
        @(negedge clk);
        chk(sat_flag == 0, "stat_clr_sat", sat_flag, 0);
        chk(coef_wr_err == 1, "stat_clr_set_wins", coef_wr_err, 1);
        tick();

        // coefficient protection and write-on-trigger
        pulse_sync();
        for (int k = 0; k < T; k++) wcoef(k, (k % 5) - 2, 1'b1);
        cfg_shift = 0;
        for (int i = 0; i < D - 1; i++) send(i * 37 - 100);
        coef_wr_addr = 0;
        coef_wr_data = 50;
        coef_wr_en   = 1'b1;
        exp_wr_ok    = 1'b1;
        send(123);
        coef_wr_en   = 1'b0;
        exp_wr_ok    = 1'b0;
        repeat (3) tick();
        wcoef(5, 999, 1'b0);
        drain();
        wcoef(63, 777, 1'b1);
        for (int i = 0; i < 2 * D; i++) send(i * 211 - 1900);
        drain();
        chk(coef_wr_err == 1, "coef_err_sticky", coef_wr_err, 1);

        // backpressure: 200 stalled cycles with the source always valid
        pulse_sync();
        obs.delete();
        fork
            begin
                for (int i = 0; i < 3 * D; i++) send(i * 1000 - 13000);
            end
            begin
                bit held;
                int cap;
                held = 1'b0;
                cap  = 0;
                dout_ready = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (held) begin
                        chk(dout_valid == 1, "bp_valid_held", dout_valid, 1);
                        chk(dout == cap, "bp_dout_stable", dout, cap);
                    end else if (dout_valid) begin
                        held = 1'b1;
                        cap  = int'(dout);
                    end
                end
                chk(held == 1, "bp_result_seen", held, 1);
                chk(din_ready == 0, "bp_din_ready_low", din_ready, 0);
                @(posedge clk);
                #1;
                dout_ready = 1'b1;
            end
        join
        drain();
        chk(obs.size() == 3, "bp_count", obs.size(), 3);

        // sync in the middle of a MAC
        pulse_sync();
        for (int i = 0; i < D; i++) send(i + 40);
        repeat (19) tick();
        pulse_sync();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (dout_valid) seen = 1'b1;
            end
            chk(seen == 0, "sync_no_valid", seen, 0);
        end
        tick();
        for (int i = 0; i < 2 * D; i++) send(i * 50 + 1);
        drain();

        // asynchronous reset in the middle of a MAC
        for (int i = 0; i < D; i++) send(300 - i);
        repeat (19) tick();
        #2;
        rst = 1'b1;
        #1;
        chk(dout == 0, "arst_dout", dout, 0);
        chk(dout_valid == 0, "arst_dout_valid", dout_valid, 0);
        chk(din_ready == 1, "arst_din_ready", din_ready, 1);
        chk(sat_flag == 0, "arst_sat_flag", sat_flag, 0);
        chk(coef_wr_err == 0, "arst_coef_wr_err", coef_wr_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // coefficients come back zeroed: one tap programmed
        obs.delete();
        cfg_shift = 0;
        wcoef(0, 3, 1'b1);
        for (int i = 0; i < D; i++) send(7);
        drain();
        chk(obs_at(0) == 21, "post_reset_lit", obs_at(0), 21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
